mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the mux161 16:1 multiplexer.
- On a start request it captures a 16-bit word and drives it onto the mux data bus.
- It then steps the 4-bit select through all 16 positions, holding each for DIV clocks, so the mux Y output becomes a serial bitstream.
- It provides busy/done status and a per-bit sample strobe for the downstream capture stage.

Parameters:
- DIV, 1, clock cycles each select value is held (legal range 1..256).
- MSB_FIRST, 0, scan order: 0 = sel 0→15, 1 = sel 15→0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled in IDLE or DONE only.
- din  input  16  word to serialize; captured on an accepted start.
- i_out  output  16  captured word, wired to mux161 I.
- sel  output  4  select, wired to mux161 S.
- busy  output  1  high while scanning; sel and i_out are stable and valid.
- strobe  output  1  high on the last cycle of each select hold (sample point for Y).
- done  output  1  one-cycle pulse after the 16th bit completes.

Behaviour:
- Reset: all state is cleared on the rising edge of clk with rst=1; rst has priority over everything.
  - State after reset: IDLE, i_out=0, sel=0, busy=0, strobe=0, done=0, hold counter=0, bit counter=0.
  - Reset mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 → capture din into i_out; sel=first index (0, or 15 if MSB_FIRST); hold cnt=0; bit cnt=0; busy=1; go to SCAN.
  - Latency: start at edge k produces busy/sel valid from edge k+1.
  - start=0 → remain in IDLE; sel and i_out keep their last values.
- SCAN:
  - Hold counter increments each cycle.
  - strobe=1 when hold cnt==DIV-1 (combinational from registered state, so coincident with the final hold cycle).
  - On the strobe cycle:
    - If bit cnt<15: hold cnt resets to 0, bit cnt increments, sel moves to next index (+1, or -1 if MSB_FIRST, 4-bit arithmetic with no wrap past the last index).
    - If bit cnt==15: go to DONE.
  - start is ignored in SCAN; din changes do not affect i_out.
  - busy stays high for exactly 16*DIV cycles.
- DONE (one cycle):
  - done=1, busy=0, strobe=0; sel holds the last index; i_out holds.
  - Next state is IDLE, unless start=1 in this cycle: then capture din and go straight to SCAN (back-to-back, no IDLE gap).
- DIV=1 case: strobe is high on every SCAN cycle; sel changes every clock.
- Counter widths: hold counter is 8 bits (covers DIV up to 256); bit counter is 4 bits.

Decomposition:
- Shared package/header (mux_pkg): state encodings (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), MUX_WIDTH=16, SEL_WIDTH=4.
- One natural sub-module, scan_divider: the DIV hold counter, with enable/clear inputs and a terminal-count (strobe) output.
- The top level contains the FSM, bit counter, sel update and i_out register.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1, din=16'hFFFF → i_out=0, sel=0, busy=0, done=0; start is not accepted during reset.
- Basic scan, DIV=1, MSB_FIRST=0, din=16'h00B6, start pulsed 1 cycle:
  - busy high 16 cycles; sel=0..15 on consecutive cycles; strobe high all 16 cycles.
  - Mux Y sequence 0,1,1,0,1,1,0,1 then 0×8.
  - done pulses 1 cycle after sel=15, with busy=0.
- Hold and order, DIV=3, MSB_FIRST=1, din=16'h8001:
  - Each sel value held 3 cycles, order 15→0; strobe on every 3rd cycle.
  - busy high 48 cycles; Y = 1, 0×14, 1 at the strobes.
- Start during SCAN: start re-pulsed at cycle 5 with din=16'h1234 → ignored; i_out stays 16'h00B6; scan completes normally.
- Back-to-back: start=1 in the DONE cycle with din=16'hA5A5 → next cycle busy=1, sel=0, i_out=16'hA5A5; no IDLE cycle between scans.
- Reset mid-scan: rst=1 at bit 7 → next edge: IDLE, all outputs 0, no done pulse; a later start scans normally.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and constants for the mux161 scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int MUX_WIDTH = 16;
    localparam int SEL_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Next select in scan order; callers never step past the last index.
    function automatic logic [SEL_WIDTH-1:0] next_sel(
        input logic [SEL_WIDTH-1:0] cur,
        input logic                 msb_first
    );
        return msb_first ? cur - 1'b1 : cur + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_divider.sv
`default_nettype none
// ============================================================================
// Module      : scan_divider
// Description : Hold counter for each select value; tc marks the last hold cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [7:0] c_TERM = 8'(DIV - 1);

    logic [7:0] r_cnt;
    logic       w_tc;

    assign w_tc = en && (r_cnt == c_TERM);
    assign tc   = w_tc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            r_cnt <= w_tc ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Captures a word and steps the mux161 select across all bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MUX_WIDTH-1:0] din,
    output logic [MUX_WIDTH-1:0] i_out,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 busy,
    output logic                 strobe,
    output logic                 done
);

    localparam logic [SEL_WIDTH-1:0] c_FIRST_SEL = MSB_FIRST ? 4'd15 : 4'd0;

    state_t               r_state;
    logic [3:0]           r_bit_cnt;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [MUX_WIDTH-1:0] r_i_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_scan;
    logic                 w_strobe;

    assign w_scan = (r_state == ST_SCAN);

    // Counter is held clear outside SCAN so every scan starts from zero.
    scan_divider #(
        .DIV (DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (w_scan),
        .clr (!w_scan),
        .tc  (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_sel     <= '0;
            r_i_out   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_strobe) begin
                        if (r_bit_cnt != 4'd15) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_sel     <= next_sel(r_sel, MSB_FIRST);
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= ST_SCAN;
                        r_i_out   <= din;
                        r_sel     <= c_FIRST_SEL;
                        r_bit_cnt <= 4'd0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign i_out  = r_i_out;
    assign sel    = r_sel;
    assign busy   = r_busy;
    assign strobe = w_strobe;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for two mux_scan_ctrl configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int c_DIV [2] = '{1, 3};
    localparam bit c_MSB [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic [15:0] din   [2];
    logic [15:0] i_out [2];
    logic [3:0]  sel   [2];
    logic        busy  [2];
    logic        strobe[2];
    logic        done  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DIV(1), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .din(din[0]),
        .i_out(i_out[0]), .sel(sel[0]), .busy(busy[0]), .strobe(strobe[0]), .done(done[0])
    );

    mux_scan_ctrl #(.DIV(3), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .din(din[1]),
        .i_out(i_out[1]), .sel(sel[1]), .busy(busy[1]), .strobe(strobe[1]), .done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is just a cycle index t in [0, 16*DIV).
    bit          m_valid = 1'b0;
    bit          m_act  [2];
    bit          m_done [2];
    int          m_t    [2];
    logic [15:0] m_word [2];
    logic [3:0]  m_last [2];

    function automatic logic [3:0] idx(input int m, input int k);
        return c_MSB[m] ? 4'(15 - k) : 4'(k);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            for (int m = 0; m < 2; m++) begin
                m_act[m] <= 1'b0; m_done[m] <= 1'b0; m_t[m] <= 0;
                m_word[m] <= 16'd0; m_last[m] <= 4'd0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (m_act[m]) begin
                    if (m_t[m] == 16 * c_DIV[m] - 1) begin
                        m_act[m]  <= 1'b0;
                        m_done[m] <= 1'b1;
                        m_last[m] <= idx(m, 15);
                    end else begin
                        m_t[m] <= m_t[m] + 1;
                    end
                end else begin
                    m_done[m] <= 1'b0;
                    if (start[m]) begin
                        m_act[m]  <= 1'b1;
                        m_t[m]    <= 0;
                        m_word[m] <= din[m];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("busy%0d", m), 32'(busy[m]), 32'(m_act[m]));
                chk($sformatf("sel%0d", m), 32'(sel[m]),
                    32'(m_act[m] ? idx(m, m_t[m] / c_DIV[m]) : m_last[m]));
                chk($sformatf("strobe%0d", m), 32'(strobe[m]),
                    32'(m_act[m] && (m_t[m] % c_DIV[m] == c_DIV[m] - 1)));
                chk($sformatf("done%0d", m), 32'(done[m]), 32'(m_done[m]));
                chk($sformatf("i_out%0d", m), 32'(i_out[m]), 32'(m_word[m]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one scan on instance m; returns busy/strobe counts and the Y bits seen at strobes.
    task automatic run_scan(input int m, input logic [15:0] word, input int inject_at,
                            output int nb, output int ns, output logic [15:0] yv);
        logic seen_done;
        start[m] = 1'b1; din[m] = word;
        step();
        start[m] = 1'b0; din[m] = 16'($urandom);
        nb = 0; ns = 0; yv = 16'd0; seen_done = 1'b0;
        for (int c = 0; c < 1000 && !seen_done; c++) begin
            if (busy[m]) nb++;
            if (strobe[m]) begin
                if (ns < 16) yv[ns] = i_out[m][sel[m]];
                ns++;
            end
            if (done[m]) seen_done = 1'b1;
            if (c == inject_at) begin
                start[m] = 1'b1; din[m] = 16'h1234;
            end else begin
                start[m] = 1'b0;
            end
            if (!seen_done) step();
        end
        chk($sformatf("done_seen%0d", m), 32'(seen_done), 32'd1);
    endtask

    int          nb, ns, n;
    logic [15:0] yv;

    initial begin
        for (int m = 0; m < 2; m++) begin
            start[m] = 1'b1; din[m] = 16'hFFFF;
        end
        rst = 1'b1;
        step(); step();
        for (int m = 0; m < 2; m++) begin
            chk("rst_iout", 32'(i_out[m]), 32'd0);
            chk("rst_sel",  32'(sel[m]),   32'd0);
            chk("rst_busy", 32'(busy[m]),  32'd0);
            chk("rst_done", 32'(done[m]),  32'd0);
            start[m] = 1'b0;
        end
        rst = 1'b0;
        step();

        // DIV=1 LSB-first scan with an ignored start at cycle 5.
        run_scan(0, 16'h00B6, 5, nb, ns, yv);
        chk("a_busy_cycles", 32'(nb), 32'd16);
        chk("a_strobes", 32'(ns), 32'd16);
        chk("a_y_bits", 32'(yv), 32'h00B6);
        chk("a_iout_kept", 32'(i_out[0]), 32'h00B6);
        chk("a_done_busy", 32'(busy[0]), 32'd0);
        chk("a_done_sel", 32'(sel[0]), 32'd15);

        // Back-to-back start from the DONE cycle.
        start[0] = 1'b1; din[0] = 16'hA5A5;
        step();
        start[0] = 1'b0;
        chk("b2b_busy", 32'(busy[0]), 32'd1);
        chk("b2b_sel", 32'(sel[0]), 32'd0);
        chk("b2b_iout", 32'(i_out[0]), 32'hA5A5);

        // Abort mid-scan at bit 7.
        n = 0;
        while (sel[0] != 4'd7 && n < 40) begin
            step(); n++;
        end
        chk("abort_reach_bit7", 32'(sel[0]), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_sel", 32'(sel[0]), 32'd0);
        chk("abort_iout", 32'(i_out[0]), 32'd0);
        chk("abort_strobe", 32'(strobe[0]), 32'd0);
        for (int c = 0; c < 20; c++) begin
            chk("abort_no_done", 32'(done[0]), 32'd0);
            step();
        end
        run_scan(0, 16'h3C5A, -1, nb, ns, yv);
        chk("r_busy_cycles", 32'(nb), 32'd16);
        chk("r_y_bits", 32'(yv), 32'h3C5A);

        // DIV=3 MSB-first scan, ignored start mid-scan.
        run_scan(1, 16'h8001, 7, nb, ns, yv);
        chk("c_busy_cycles", 32'(nb), 32'd48);
        chk("c_strobes", 32'(ns), 32'd16);
        chk("c_y_bits", 32'(yv), 32'h8001);
        chk("c_iout_kept", 32'(i_out[1]), 32'h8001);
        chk("c_done_sel", 32'(sel[1]), 32'd0);
        step(); step();

        // Random traffic on both instances, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                start[m] = ($urandom_range(0, 7) == 0);
                din[m]   = 16'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
